// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP layer control blocks.
package mlp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        ACCUM  = 3'd2,
        ACT    = 3'd3,
        OUTPUT = 3'd4,
        DONE   = 3'd5
    } seq_state_t;

    // $clog2 that never returns 0, so a one-entry index still gets a 1-bit port.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_sequencer.sv
// Layer sequencer: drives one shared neuron MAC datapath across every neuron of
// a layer (clear, NUM_INPUTS accumulate steps, bias+ReLU) and hands each result
// to a valid/ready consumer.
// Optional: define LAYER_SEQ_PERF_EN to add the perf_cycles busy-cycle counter.
module layer_sequencer
    import mlp_pkg::*;
#(
    parameter int NUM_INPUTS  = 10,
    parameter int NUM_NEURONS = 4,
    parameter int DATA_BITS   = 24,
    localparam int IDX_W      = clog2_min1(NUM_INPUTS),
    localparam int NID_W      = clog2_min1(NUM_NEURONS)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 mac_clear,
    output logic                 mac_en,
    output logic                 act_en,
    output logic [IDX_W-1:0]     in_idx,
    output logic [NID_W-1:0]     neuron_idx,
    input  logic [DATA_BITS-1:0] mac_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
`ifdef LAYER_SEQ_PERF_EN
    output logic [31:0]          perf_cycles,
`endif
    output logic [NID_W-1:0]     out_idx
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_INPUTS - 1);
    localparam logic [NID_W-1:0] NID_LAST = NID_W'(NUM_NEURONS - 1);

    seq_state_t           state_q, state_d;
    logic [IDX_W-1:0]     in_idx_q, in_idx_d;
    logic [NID_W-1:0]     neuron_idx_q, neuron_idx_d;
    logic [NID_W-1:0]     out_idx_q, out_idx_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    // High only in the first OUTPUT cycle: mac_result is forwarded directly then,
    // and held in out_data_q from the following cycle on.
    logic                 out_first_q, out_first_d;

    // State and datapath-control registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            in_idx_q     <= '0;
            neuron_idx_q <= '0;
            out_idx_q    <= '0;
            out_data_q   <= '0;
            out_first_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            in_idx_q     <= in_idx_d;
            neuron_idx_q <= neuron_idx_d;
            out_idx_q    <= out_idx_d;
            out_data_q   <= out_data_d;
            out_first_q  <= out_first_d;
        end
    end

    // Next-state and index sequencing; abort overrides everything below it.
    always_comb begin
        state_d      = state_q;
        in_idx_d     = in_idx_q;
        neuron_idx_d = neuron_idx_q;
        out_idx_d    = out_idx_q;
        out_data_d   = out_data_q;
        out_first_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = CLEAR;
                    neuron_idx_d = '0;
                    in_idx_d     = '0;
                end
            end
            CLEAR: begin
                in_idx_d = '0;
                state_d  = ACCUM;
            end
            ACCUM: begin
                // Terminal-count compare keeps in_idx from wrapping.
                if (in_idx_q == IDX_LAST) begin
                    in_idx_d = '0;
                    state_d  = ACT;
                end else begin
                    in_idx_d = in_idx_q + IDX_W'(1);
                end
            end
            ACT: begin
                out_idx_d   = neuron_idx_q;
                out_first_d = 1'b1;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                if (out_first_q) out_data_d = mac_result;
                if (out_ready) begin
                    if (neuron_idx_q == NID_LAST) begin
                        state_d = DONE;
                    end else begin
                        neuron_idx_d = neuron_idx_q + NID_W'(1);
                        state_d      = CLEAR;
                    end
                end
            end
            DONE: begin
                neuron_idx_d = '0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d      = IDLE;
            in_idx_d     = '0;
            neuron_idx_d = '0;
            out_idx_d    = '0;
            out_first_d  = 1'b0;
        end
    end

    // Strobes decode straight from the state, so they are one-hot by construction.
    always_comb begin
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        mac_clear  = (state_q == CLEAR);
        mac_en     = (state_q == ACCUM);
        act_en     = (state_q == ACT);
        out_valid  = (state_q == OUTPUT);
        in_idx     = in_idx_q;
        neuron_idx = neuron_idx_q;
        out_idx    = out_idx_q;
        out_data   = out_first_q ? mac_result : out_data_q;
    end

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: restarts on an accepted start, saturates, holds in IDLE.
    always_comb begin
        perf_d = perf_q;
        if (state_q == IDLE) begin
            if (start) perf_d = '0;
        end else if (perf_q != 32'hFFFF_FFFF) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: behavioural MAC datapath, randomized rows and
// backpressure, outputs checked against sum(w*a)+b with ReLU.
module tb_layer_sequencer;

    localparam int NI = 10;
    localparam int NN = 4;
    localparam int DB = 24;
    localparam int IW = 4;
    localparam int NW = 2;

    logic          clk = 1'b0;
    logic          rstn, start, abort, out_ready;
    logic          busy, done, mac_clear, mac_en, act_en, out_valid;
    logic [IW-1:0] in_idx;
    logic [NW-1:0] neuron_idx, out_idx;
    logic [DB-1:0] mac_result, out_data;
`ifdef LAYER_SEQ_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    always #5 clk = ~clk;

    layer_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN), .DATA_BITS(DB)) dut (
        .clk(clk), .rstn(rstn), .start(start), .abort(abort),
        .busy(busy), .done(done), .mac_clear(mac_clear), .mac_en(mac_en),
        .act_en(act_en), .in_idx(in_idx), .neuron_idx(neuron_idx),
        .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data),
`ifdef LAYER_SEQ_PERF_EN
        .perf_cycles(perf_cycles),
`endif
        .out_idx(out_idx)
    );

    int dat[NN][NI];
    int wt[NN][NI];
    int bias[NN];

    // Behavioural neuron datapath: accumulator plus registered bias+ReLU result.
    longint        acc;
    logic [DB-1:0] res_q;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc   <= 0;
            res_q <= '0;
        end else begin
            if (mac_clear) acc <= 0;
            else if (mac_en && in_idx < NI)
                acc <= acc + longint'(dat[neuron_idx][in_idx] * wt[neuron_idx][in_idx]);
            if (act_en) res_q <= (acc + bias[neuron_idx] < 0) ? '0 : DB'(acc + bias[neuron_idx]);
        end
    end
    assign mac_result = res_q;

    int n_chk  = 0;
    int n_fail = 0;
    int viol   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: layer output for neuron n straight from the row tables.
    function automatic longint ref_out(input int n);
        longint s = bias[n];
        for (int i = 0; i < NI; i++) s += dat[n][i] * wt[n][i];
        return (s < 0) ? 0 : s;
    endfunction

    task automatic rand_row(input int n);
        for (int i = 0; i < NI; i++) begin
            dat[n][i] = int'($urandom_range(0, 31)) - 16;
            wt[n][i]  = int'($urandom_range(0, 15)) - 8;
        end
        bias[n] = int'($urandom_range(0, 100)) - 50;
    endtask

    int     o_idx[$];
    longint o_dat[$];

    // One layer run. mode 0: always ready, 1: random ready, 2: 5-cycle stall on neuron 1.
    // hold keeps start high all the way through. done_c is the cycle done was seen
    // (cycle 0 = start sampled), -1 on timeout.
    task automatic run_layer(input int mode, input bit hold, output int done_c, output int stalls);
        int            stall_left;
        bit            pv;
        logic [DB-1:0] pd;
        logic [NW-1:0] pi;
        o_idx.delete();
        o_dat.delete();
        done_c     = -1;
        stalls     = 0;
        stall_left = 5;
        pv         = 1'b0;
        pd         = '0;
        pi         = '0;
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= 400 && done_c < 0; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done) done_c = c;
            if (!busy) viol++;
            if (int'(mac_clear) + int'(mac_en) + int'(act_en) > 1) viol++;
            if (in_idx >= IW'(NI)) viol++;
            if (pv && (out_data !== pd || out_idx !== pi)) viol++;
            if (mode == 2 && out_valid && out_idx == 2'd1 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            pv = out_valid && !out_ready;
            pd = out_data;
            pi = out_idx;
            if (pv) begin
                stalls++;
                if (mac_en || act_en) viol++;
            end
            if (out_valid && out_ready) begin
                o_idx.push_back(int'(out_idx));
                o_dat.push_back(longint'(out_data));
            end
        end
        out_ready = 1'b1;
        if (done_c < 0) chk("layer_timeout", 0, 1);
    endtask

    task automatic verify_outputs(input string tag);
        chk({tag, "_count"}, o_idx.size(), NN);
        for (int i = 0; i < NN && i < o_idx.size(); i++) begin
            chk({tag, "_idx"}, o_idx[i], i);
            chk({tag, "_data"}, o_dat[i], ref_out(i));
        end
    endtask

    initial begin
        int  dc, st, found, clears, seen;
        int  d0[NI] = '{-2, 5, -1, 10, 3, -4, 7, -6, 2, 8};
        int  w0[NI] = '{3, 2, 8, 10, 1, 2, 4, 3, 5, 2};

        rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < NI; i++) begin
            dat[0][i] = d0[i];
            wt[0][i]  = w0[i];
            dat[2][i] = 0;
            wt[2][i]  = 1;
        end
        bias[0] = 5;
        dat[2][0] = -5; wt[2][0] = 9; bias[2] = 5;   // sum = -40
        rand_row(1);
        rand_row(3);

        #12;
        chk("reset_ctrl", {busy, done, mac_clear, mac_en, act_en, out_valid}, 0);
        chk("reset_idx", {in_idx, neuron_idx, out_idx}, 0);
        chk("reset_data", out_data, 0);
        @(negedge clk) rstn = 1'b1;

        // Directed layer: known row 0, ReLU-clamped row 2.
        run_layer(0, 1'b0, dc, st);
        chk("t1_done_cycle", dc, 53);
        verify_outputs("t1");
        if (o_dat.size() > 2) begin
            chk("t1_row0", o_dat[0], 132);
            chk("t2_relu_zero", o_dat[2], 0);
        end
        @(negedge clk);
        chk("t1_idle_after", busy, 0);
`ifdef LAYER_SEQ_PERF_EN
        chk("t6_perf", perf_cycles, 53);
`endif

        // Backpressure on neuron 1.
        run_layer(2, 1'b0, dc, st);
        chk("t3_stalls", st, 5);
        chk("t3_done_cycle", dc, 58);
        verify_outputs("t3");
`ifdef LAYER_SEQ_PERF_EN
        @(negedge clk);
        chk("t3_perf", perf_cycles, 58);
`endif

        // Random rows with random backpressure.
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < NN; n++) rand_row(n);
            run_layer(1, 1'b0, dc, st);
            chk("rand_done_cycle", dc, NN * (NI + 3) + 1 + st);
            verify_outputs("rand");
        end

        // Abort in ACCUM of neuron 2 at in_idx 4.
        found = 0;
        @(negedge clk) start = 1'b1;
        for (int c = 0; c < 200 && found == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (mac_en && neuron_idx == 2'd2 && in_idx == 4'd4) begin
                abort = 1'b1;
                found = 1;
            end
        end
        chk("t4_abort_point", found, 1);
        @(negedge clk);
        abort = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_idx", {in_idx, neuron_idx, out_valid}, 0);
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("t4_no_done", seen, 0);
        for (int n = 0; n < NN; n++) rand_row(n);
        run_layer(0, 1'b0, dc, st);
        chk("t4_restart_done", dc, 53);
        verify_outputs("t4");

        // start held high: reset asserted mid-OUTPUT.
        found = 0; clears = 0; seen = 0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        for (int c = 1; c < 100 && found == 0; c++) begin
            @(negedge clk);
            if (mac_clear) clears++;
            if (out_valid) begin
                found = 1;
                seen  = c;
            end
        end
        chk("t5_first_output_cycle", seen, NI + 3);
        chk("t5_single_clear", clears, 1);
        #2 rstn = 1'b0;
        #1;
        chk("t5_rst_ctrl", {busy, done, mac_clear, mac_en, act_en, out_valid}, 0);
        chk("t5_rst_idx", {in_idx, neuron_idx, out_idx}, 0);
        chk("t5_rst_data", out_data, 0);
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk) rstn = 1'b1;

        // start held through the whole layer, including DONE.
        run_layer(0, 1'b1, dc, st);
        chk("t5_hold_done", dc, 53);
        verify_outputs("t5");
        @(negedge clk);
        chk("t5_done_start_ignored", busy, 0);
        @(negedge clk);
        chk("t5_restart_next", busy, 1);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_abort_idle", busy, 0);

        chk("invariants", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
